// File: rtl/eeprom_rw_ctrl.sv
// rtl/eeprom_rw_ctrl.sv - EEPROM block write / read-back / compare sequencer
module eeprom_rw_ctrl #(
    parameter int unsigned CLK_FREQ     = 32'd50_000_000,
    parameter int unsigned BYTE_NUM     = 16,
    parameter logic [15:0] START_ADDR   = 16'h0000,
    parameter logic        ADDR_16BIT   = 1'b1,
    parameter logic [7:0]  DATA_SEED    = 8'hA5,
    parameter int unsigned WR_DELAY_CYC = 250_000,
    parameter int unsigned TIMEOUT_CYC  = 1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        i2c_exec,
    output logic        i2c_we,
    output logic        i2c_addr_hl,
    output logic [15:0] i2c_word_addr,
    output logic [7:0]  i2c_wdata,
    input  logic [7:0]  i2c_rdata,
    input  logic        i2c_done,
    output logic        busy,
    output logic        pass,
    output logic        fail,
    output logic        timeout,
    output logic [7:0]  err_cnt,
    output logic [7:0]  rd_byte
);

    localparam int DW = (WR_DELAY_CYC > 1) ? $clog2(WR_DELAY_CYC) : 1;
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [7:0] LAST_IDX  = 8'(BYTE_NUM - 1);
    localparam logic [DW-1:0] DLY_END = DW'(WR_DELAY_CYC - 1);
    localparam logic [TW-1:0] TMO_END = TW'(TIMEOUT_CYC - 1);

    // Reject parameter sets the sequencer cannot honour at elaboration time.
    if (BYTE_NUM < 1 || BYTE_NUM > 256 || WR_DELAY_CYC < 1 || TIMEOUT_CYC < 1 || CLK_FREQ == 0) begin : g_bad_params
        $error("eeprom_rw_ctrl: illegal parameter set");
    end

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_WAIT,
        WR_DLY,
        RD_REQ,
        RD_WAIT,
        FINISH
    } state_t;

    state_t        state;
    logic [7:0]    index;
    logic          done_d;
    logic [DW-1:0] dly_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          done_rise;
    logic [7:0]    exp_byte;

    // A done held for several cycles must advance the sequence only once.
    assign done_rise   = i2c_done & ~done_d;
    assign exp_byte    = index + DATA_SEED;
    assign i2c_addr_hl = ADDR_16BIT;

    // Sequencer: write pass, per-byte write-cycle delay, read-back compare, verdict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            index         <= 8'd0;
            done_d        <= 1'b0;
            dly_cnt       <= '0;
            tmo_cnt       <= '0;
            i2c_exec      <= 1'b0;
            i2c_we        <= 1'b0;
            i2c_word_addr <= START_ADDR;
            i2c_wdata     <= DATA_SEED;
            busy          <= 1'b0;
            pass          <= 1'b0;
            fail          <= 1'b0;
            timeout       <= 1'b0;
            err_cnt       <= 8'd0;
            rd_byte       <= 8'd0;
        end else begin
            done_d   <= i2c_done;
            i2c_exec <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        pass    <= 1'b0;
                        fail    <= 1'b0;
                        timeout <= 1'b0;
                        err_cnt <= 8'd0;
                        index   <= 8'd0;
                        busy    <= 1'b1;
                        state   <= WR_REQ;
                    end
                end
                WR_REQ: begin
                    // Address/data stay registered through the wait; the driver samples them late.
                    i2c_exec      <= 1'b1;
                    i2c_we        <= 1'b1;
                    i2c_word_addr <= START_ADDR + {8'h00, index};
                    i2c_wdata     <= exp_byte;
                    tmo_cnt       <= '0;
                    state         <= WR_WAIT;
                end
                WR_WAIT: begin
                    if (done_rise) begin
                        dly_cnt <= '0;
                        state   <= WR_DLY;
                    end else if (tmo_cnt == TMO_END) begin
                        timeout <= 1'b1;
                        state   <= FINISH;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                WR_DLY: begin
                    if (dly_cnt == DLY_END) begin
                        dly_cnt <= '0;
                        if (index == LAST_IDX) begin
                            index <= 8'd0;
                            state <= RD_REQ;
                        end else begin
                            index <= index + 8'd1;
                            state <= WR_REQ;
                        end
                    end else begin
                        dly_cnt <= dly_cnt + 1'b1;
                    end
                end
                RD_REQ: begin
                    i2c_exec      <= 1'b1;
                    i2c_we        <= 1'b0;
                    i2c_word_addr <= START_ADDR + {8'h00, index};
                    i2c_wdata     <= exp_byte;
                    tmo_cnt       <= '0;
                    state         <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (done_rise) begin
                        rd_byte <= i2c_rdata;
                        if (i2c_rdata != i2c_wdata && err_cnt != 8'hFF) begin
                            err_cnt <= err_cnt + 8'd1;
                        end
                        if (index == LAST_IDX) begin
                            state <= FINISH;
                        end else begin
                            index <= index + 8'd1;
                            state <= RD_REQ;
                        end
                    end else if (tmo_cnt == TMO_END) begin
                        timeout <= 1'b1;
                        state   <= FINISH;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    pass  <= ~timeout & (err_cnt == 8'd0);
                    fail  <= timeout | (err_cnt != 8'd0);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eeprom_rw_ctrl.sv
// tb/tb_eeprom_rw_ctrl.sv - scoreboard bench for eeprom_rw_ctrl with an I2C driver model
module tb_eeprom_rw_ctrl;

    localparam int WR_DLY = 20;
    localparam int TMO    = 500;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start0 = 1'b0;
    logic start1 = 1'b0;
    logic done = 1'b0;
    logic [7:0] rdata = 8'h00;
    logic sel = 1'b0;

    logic        exec0, we0, hl0, busy0, pass0, fail0, to0;
    logic [15:0] waddr0;
    logic [7:0]  wdata0, err0, rdb0;
    logic        exec1, we1, hl1, busy1, pass1, fail1, to1;
    logic [15:0] waddr1;
    logic [7:0]  wdata1, err1, rdb1;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    eeprom_rw_ctrl #(
        .BYTE_NUM(4), .START_ADDR(16'h0000), .ADDR_16BIT(1'b1), .DATA_SEED(8'hA5),
        .WR_DELAY_CYC(WR_DLY), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start0),
        .i2c_exec(exec0), .i2c_we(we0), .i2c_addr_hl(hl0), .i2c_word_addr(waddr0),
        .i2c_wdata(wdata0), .i2c_rdata(rdata), .i2c_done(done),
        .busy(busy0), .pass(pass0), .fail(fail0), .timeout(to0), .err_cnt(err0), .rd_byte(rdb0)
    );

    eeprom_rw_ctrl #(
        .BYTE_NUM(1), .START_ADDR(16'h0000), .ADDR_16BIT(1'b1), .DATA_SEED(8'hA5),
        .WR_DELAY_CYC(WR_DLY), .TIMEOUT_CYC(TMO)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .i2c_exec(exec1), .i2c_we(we1), .i2c_addr_hl(hl1), .i2c_word_addr(waddr1),
        .i2c_wdata(wdata1), .i2c_rdata(rdata), .i2c_done(done),
        .busy(busy1), .pass(pass1), .fail(fail1), .timeout(to1), .err_cnt(err1), .rd_byte(rdb1)
    );

    wire        m_exec = sel ? exec1  : exec0;
    wire        m_we   = sel ? we1    : we0;
    wire [15:0] m_addr = sel ? waddr1 : waddr0;
    wire [7:0]  m_wdat = sel ? wdata1 : wdata0;
    wire        m_busy = sel ? busy1  : busy0;
    wire        m_pass = sel ? pass1  : pass0;
    wire        m_fail = sel ? fail1  : fail0;
    wire        m_to   = sel ? to1    : to0;
    wire [7:0]  m_err  = sel ? err1   : err0;

    int errors = 0;
    int checks = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    typedef struct {
        bit          fin;
        bit          we;
        logic [15:0] addr;
        logic [7:0]  data;
        bit          ps;
        bit          fl;
        bit          to;
        logic [7:0]  ec;
    } exp_t;

    exp_t q[$];

    function automatic void push_exec(input bit we, input int idx, input logic [7:0] data);
        exp_t e;
        e.fin = 1'b0; e.we = we; e.addr = 16'(idx); e.data = data;
        e.ps = 1'b0; e.fl = 1'b0; e.to = 1'b0; e.ec = 8'h00;
        q.push_back(e);
    endfunction

    function automatic void push_fin(input bit ps, input bit fl, input bit to, input logic [7:0] ec);
        exp_t e;
        e.fin = 1'b1; e.we = 1'b0; e.addr = 16'h0; e.data = 8'h0;
        e.ps = ps; e.fl = fl; e.to = to; e.ec = ec;
        q.push_back(e);
    endfunction

    // Driver model: done for done_len cycles, 60 cycles after each exec; reads return stored bytes.
    int pend = 0, hold = 0, spur = 0;
    int done_len = 3, hang_wr = -1, corrupt_addr = -1;
    int wr_cnt = 0, done_cnt = 0, last_done_cyc = 0;
    bit spur_en = 1'b0, p_we = 1'b0, last_done_we = 1'b0;
    logic [15:0] p_addr = 16'h0;
    logic [7:0]  mem [4];

    initial begin
        forever begin
            @(negedge clk);
            if (hold > 0) hold--;
            if (spur > 0) spur--;
            if (m_exec) begin
                p_we = m_we;
                p_addr = m_addr;
                if (m_we) begin
                    mem[m_addr[1:0]] = m_wdat;
                    wr_cnt++;
                end
                pend = (m_we && wr_cnt == hang_wr) ? 0 : 60;
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    if (p_we) rdata = 8'h00;
                    else if (int'(p_addr) == corrupt_addr) rdata = 8'h00;
                    else rdata = mem[p_addr[1:0]];
                    hold = done_len;
                    done_cnt++;
                    last_done_cyc = cyc;
                    last_done_we = p_we;
                    if (p_we && spur_en) spur = 8;
                end
            end
            done = (hold > 0) || (spur == 1);
        end
    end

    // Monitor: pops the scoreboard on every exec and on every busy fall.
    initial begin
        exp_t e;
        bit exec_prev = 1'b0, busy_prev = 1'b0, to_prev = 1'b0;
        int exec_cyc = 0, base = 0;
        forever begin
            @(negedge clk);
            if (m_busy && !busy_prev) base = done_cnt;
            if (m_exec) begin
                chk("exec_width", exec_prev, 0);
                if (q.size() == 0 || q[0].fin) begin
                    checks++;
                    errors++;
                    $display("FAIL exec_unexpected: actual addr=%0h we=%0b, required no exec", m_addr, m_we);
                end else begin
                    e = q.pop_front();
                    chk("exec_fields", {m_we, m_addr, m_wdat}, {e.we, e.addr, e.data});
                end
                if (done_cnt > base)
                    chk("exec_gap", cyc - last_done_cyc, last_done_we ? WR_DLY + 2 : 2);
                exec_cyc = cyc;
            end
            if (m_to && !to_prev) chk("timeout_latency", cyc - exec_cyc, TMO);
            if (!m_busy && busy_prev) begin
                if (q.size() == 0 || !q[0].fin) begin
                    checks++;
                    errors++;
                    $display("FAIL finish_unexpected: actual busy fell, required %0d pending execs", q.size());
                end else begin
                    e = q.pop_front();
                    chk("finish_flags", {m_pass, m_fail, m_to, m_err}, {e.ps, e.fl, e.to, e.ec});
                end
            end
            exec_prev = m_exec;
            busy_prev = m_busy;
            to_prev = m_to;
        end
    end

    task automatic pulse_start(input bit which);
        @(posedge clk); #2;
        if (which) start1 = 1'b1; else start0 = 1'b1;
        @(posedge clk); #2;
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((q.size() != 0 || m_busy) && n < budget) begin
            @(posedge clk); #2;
            n++;
        end
        chk("drain_in_budget", n < budget, 1);
        if (n >= budget) q.delete();
    endtask

    task automatic push_seq(input int nbytes);
        for (int i = 0; i < nbytes; i++) push_exec(1'b1, i, 8'hA5 + 8'(i));
        for (int i = 0; i < nbytes; i++) push_exec(1'b0, i, 8'hA5 + 8'(i));
    endtask

    task automatic run_pass(input bit which, input int nbytes);
        push_seq(nbytes);
        push_fin(1'b1, 1'b0, 1'b0, 8'h00);
        pulse_start(which);
        wait_drain(4000);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_outs", {exec0, we0, busy0, pass0, fail0, to0, err0, rdb0}, 0);
        chk("rst_addr", waddr0, 16'h0000);
        chk("rst_wdata", wdata0, 8'hA5);
        chk("rst_addr_hl", hl0, 1);
        rst_n = 1'b1;

        // Normal run: A5..A8 to 0..3, read back, plus a start pulse while busy.
        push_exec(1'b1, 0, 8'hA5); push_exec(1'b1, 1, 8'hA6);
        push_exec(1'b1, 2, 8'hA7); push_exec(1'b1, 3, 8'hA8);
        push_exec(1'b0, 0, 8'hA5); push_exec(1'b0, 1, 8'hA6);
        push_exec(1'b0, 2, 8'hA7); push_exec(1'b0, 3, 8'hA8);
        push_fin(1'b1, 1'b0, 1'b0, 8'h00);
        pulse_start(1'b0);
        @(negedge clk);
        chk("start_busy_lat", {busy0, exec0}, 2'b10);
        @(negedge clk);
        chk("start_exec_lat", exec0, 1);
        repeat (30) @(posedge clk);
        pulse_start(1'b0);
        wait_drain(4000);
        chk("normal_rd_byte", rdb0, 8'hA8);

        // Corrupted read at address 2.
        corrupt_addr = 2;
        push_seq(4);
        push_fin(1'b0, 1'b1, 1'b0, 8'h01);
        pulse_start(1'b0);
        wait_drain(4000);
        corrupt_addr = -1;
        chk("corrupt_rd_byte", rdb0, 8'hA8);

        // Second write never completes.
        hang_wr = wr_cnt + 2;
        push_exec(1'b1, 0, 8'hA5);
        push_exec(1'b1, 1, 8'hA6);
        push_fin(1'b0, 1'b1, 1'b1, 8'h00);
        pulse_start(1'b0);
        wait_drain(4000);
        repeat (150) @(posedge clk);
        hang_wr = -1;

        // Done held for 10 cycles.
        done_len = 10;
        run_pass(1'b0, 4);
        done_len = 3;

        // Extra done pulse inside each write delay.
        spur_en = 1'b1;
        run_pass(1'b0, 4);
        spur_en = 1'b0;

        // Reset in the middle of the read pass.
        push_seq(2);
        q.delete();
        push_seq(4);
        for (int i = 0; i < 2; i++) void'(q.pop_back());
        push_fin(1'b0, 1'b0, 1'b0, 8'h00);
        pulse_start(1'b0);
        n = 0;
        while (q.size() > 1 && n < 4000) begin
            @(posedge clk); #2;
            n++;
        end
        chk("reach_mid_read", n < 4000, 1);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("midrst_outs", {exec0, we0, busy0, pass0, fail0, to0, err0, rdb0}, 0);
        chk("midrst_addr", {waddr0, wdata0}, {16'h0000, 8'hA5});
        rst_n = 1'b1;
        if (q.size() != 0) q.delete();
        repeat (100) @(posedge clk);
        run_pass(1'b0, 4);

        // Single-byte instance.
        sel = 1'b1;
        run_pass(1'b1, 1);
        chk("byte1_rd_byte", rdb1, 8'hA5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
